param_mem_serdes: RTL and testbench

Nibble-serial data-memory interface for the Nibbler core, sitting between the nibble-wide lane datapath and the 32-bit data memory port. For loads it issues a single 32-bit memory request, then aligns, extends and streams the result back to the lane as eight 4-bit nibbles, LSB first. For stores it collects eight nibbles from the lane, positions them in a 32-bit word and issues the write. It replaces the datapath's hard-wired `dmemreq_msg_data = 0` path.

---
 rtl/param_mem_serdes_pkg.sv | 32 +++
 rtl/param_mem_serdes_align.sv | 30 +++
 rtl/param_mem_serdes.sv | 194 +++++++++++++++++++
 tb/tb_param_mem_serdes.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/param_mem_serdes_pkg.sv
// Shared types and constants for the nibble-serial data-memory interface.
// Optional response-bypass feature: PARAM_MEM_SERDES_RESP_BYPASS_EN (see top).
package param_mem_serdes_pkg;

    localparam int P_NBITS   = 4;
    localparam int C_N_OFF   = 8;
    localparam int C_OFFBITS = 3;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        ST_COLLECT,
        REQ,
        WAIT_RESP,
        LD_STREAM
    } state_t;

    // Reserved size 3 behaves as a word access.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == 2'd3) ? SZ_W : size;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic [1:0] sz;
        sz = norm_size(size);
        return ((sz == SZ_H) && lo[0]) || ((sz == SZ_W) && (lo != 2'd0));
    endfunction

endpackage

// File: rtl/param_mem_serdes_align.sv
// Load-direction aligner: shifts the addressed byte lane down to bit 0 and
// zero- or sign-extends byte and half results to 32 bits.
module param_mem_align
    import param_mem_serdes_pkg::*;
(
    input  logic [31:0] data,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sext,
    output logic [31:0] result
);

    logic [31:0]        shifted;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    assign shifted = data >> {offset, 3'b000};
    assign byte_s  = shifted[7:0];
    assign half_s  = shifted[15:0];

    always_comb begin
        result = shifted;
        case (size)
            SZ_B:    result = sext ? 32'(byte_s) : {24'd0, shifted[7:0]};
            SZ_H:    result = sext ? 32'(half_s) : {16'd0, shifted[15:0]};
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/param_mem_serdes.sv
// Nibble-serial <-> 32-bit data-memory bridge for the Nibbler lane datapath.
// Define PARAM_MEM_SERDES_RESP_BYPASS_EN to stream nibble 0 in the response cycle.
module param_mem_serdes #(
    parameter int P_NBITS   = param_mem_serdes_pkg::P_NBITS,
    parameter int C_N_OFF   = param_mem_serdes_pkg::C_N_OFF,
    parameter int C_OFFBITS = param_mem_serdes_pkg::C_OFFBITS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mem_start_Xhl,
    input  logic               mem_rw_Xhl,
    input  logic [1:0]         mem_size_Xhl,
    input  logic               mem_sext_Xhl,
    input  logic [31:0]        addr_in_Xhl,
    input  logic [P_NBITS-1:0] st_nibble_Xhl,
    input  logic               st_nibble_val_Xhl,
    output logic               dmemreq_val,
    input  logic               dmemreq_rdy,
    output logic               dmemreq_msg_rw,
    output logic [1:0]         dmemreq_msg_len,
    output logic [31:0]        dmemreq_msg_addr,
    output logic [31:0]        dmemreq_msg_data,
    input  logic               dmemresp_val,
    input  logic [31:0]        dmemresp_msg_data,
    output logic [P_NBITS-1:0] ld_nibble_Xhl,
    output logic               ld_nibble_val_Xhl,
    output logic               busy_Xhl,
    output logic               done_Xhl,
    output logic               misalign_Xhl
);
    import param_mem_serdes_pkg::*;

    localparam logic [C_OFFBITS-1:0] C_LAST = C_OFFBITS'(C_N_OFF - 1);

    state_t               state, state_next;
    logic [C_OFFBITS-1:0] idx;
    logic [31:0]          addr_r;
    logic [1:0]           size_r;
    logic                 sext_r;
    logic                 rw_r;
    logic [31:0]          word_r;
    logic [31:0]          word_collect;
    logic [31:0]          aligned;
    logic [1:0]           start_size;
    logic                 start_misal;
    logic                 accept, collect, collect_last, handshake, resp_ld;
    logic                 ld_val;
    logic [P_NBITS-1:0]   ld_src;

    assign start_size  = norm_size(mem_size_Xhl);
    assign start_misal = is_misaligned(mem_size_Xhl, addr_in_Xhl[1:0]);

    param_mem_align u_align (
        .data   (dmemresp_msg_data),
        .offset (addr_r[1:0]),
        .size   (size_r),
        .sext   (sext_r),
        .result (aligned)
    );

    always_comb begin
        word_collect = word_r;
        word_collect[idx*P_NBITS +: P_NBITS] = st_nibble_Xhl;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next   = state;
        accept       = 1'b0;
        collect      = 1'b0;
        collect_last = 1'b0;
        handshake    = 1'b0;
        resp_ld      = 1'b0;
        done_Xhl     = 1'b0;
        ld_val       = 1'b0;
        ld_src       = word_r[idx*P_NBITS +: P_NBITS];
        case (state)
            IDLE: begin
                if (mem_start_Xhl) begin
                    accept = 1'b1;
                    // A misaligned start parks one cycle in REQ (no request) to report done.
                    if (start_misal)     state_next = REQ;
                    else if (mem_rw_Xhl) state_next = ST_COLLECT;
                    else                 state_next = REQ;
                end
            end
            ST_COLLECT: begin
                if (st_nibble_val_Xhl) begin
                    collect = 1'b1;
                    if (idx == C_LAST) begin
                        collect_last = 1'b1;
                        state_next   = REQ;
                    end
                end
            end
            REQ: begin
                if (misalign_Xhl) begin
                    done_Xhl   = 1'b1;
                    state_next = IDLE;
                end else if (dmemreq_val && dmemreq_rdy) begin
                    handshake  = 1'b1;
                    state_next = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                if (dmemresp_val) begin
                    if (rw_r) begin
                        done_Xhl   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        resp_ld    = 1'b1;
                        state_next = LD_STREAM;
`ifdef PARAM_MEM_SERDES_RESP_BYPASS_EN
                        ld_val     = 1'b1;
                        ld_src     = aligned[P_NBITS-1:0];
`endif
                    end
                end
            end
            LD_STREAM: begin
                ld_val = 1'b1;
                if (idx == C_LAST) begin
                    done_Xhl   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy_Xhl          = (state != IDLE);
    assign ld_nibble_val_Xhl = ld_val;
    assign ld_nibble_Xhl     = ld_val ? ld_src : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx              <= '0;
            addr_r           <= '0;
            size_r           <= SZ_B;
            sext_r           <= 1'b0;
            rw_r             <= 1'b0;
            word_r           <= '0;
            misalign_Xhl     <= 1'b0;
            dmemreq_val      <= 1'b0;
            dmemreq_msg_rw   <= 1'b0;
            dmemreq_msg_len  <= 2'd0;
            dmemreq_msg_addr <= '0;
            dmemreq_msg_data <= '0;
        end else begin
            if (accept) begin
                addr_r       <= addr_in_Xhl;
                size_r       <= start_size;
                sext_r       <= mem_sext_Xhl;
                rw_r         <= mem_rw_Xhl;
                idx          <= '0;
                word_r       <= '0;
                misalign_Xhl <= start_misal;
                if (!start_misal && !mem_rw_Xhl) begin
                    dmemreq_val      <= 1'b1;
                    dmemreq_msg_rw   <= 1'b0;
                    dmemreq_msg_len  <= start_size;
                    dmemreq_msg_addr <= addr_in_Xhl;
                    dmemreq_msg_data <= '0;
                end
            end
            if (collect) begin
                word_r <= word_collect;
                idx    <= idx + 1'b1;
            end
            if (collect_last) begin
                dmemreq_val      <= 1'b1;
                dmemreq_msg_rw   <= 1'b1;
                dmemreq_msg_len  <= size_r;
                dmemreq_msg_addr <= addr_r;
                dmemreq_msg_data <= word_collect << {addr_r[1:0], 3'b000};
            end
            if (handshake) dmemreq_val <= 1'b0;
            if (resp_ld) begin
                word_r <= aligned;
`ifdef PARAM_MEM_SERDES_RESP_BYPASS_EN
                idx    <= C_OFFBITS'(1);
`else
                idx    <= '0;
`endif
            end
            if (state == LD_STREAM) idx <= idx + 1'b1;
        end
    end

endmodule

// File: tb/tb_param_mem_serdes.sv
// Directed self-checking bench for param_mem_serdes (default or bypass build).
module tb_param_mem_serdes;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_start_Xhl = 1'b0;
    logic        mem_rw_Xhl = 1'b0;
    logic [1:0]  mem_size_Xhl = 2'd0;
    logic        mem_sext_Xhl = 1'b0;
    logic [31:0] addr_in_Xhl = '0;
    logic [3:0]  st_nibble_Xhl = '0;
    logic        st_nibble_val_Xhl = 1'b0;
    logic        dmemreq_val;
    logic        dmemreq_rdy = 1'b0;
    logic        dmemreq_msg_rw;
    logic [1:0]  dmemreq_msg_len;
    logic [31:0] dmemreq_msg_addr;
    logic [31:0] dmemreq_msg_data;
    logic        dmemresp_val = 1'b0;
    logic [31:0] dmemresp_msg_data = '0;
    logic [3:0]  ld_nibble_Xhl;
    logic        ld_nibble_val_Xhl;
    logic        busy_Xhl;
    logic        done_Xhl;
    logic        misalign_Xhl;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef PARAM_MEM_SERDES_RESP_BYPASS_EN
    localparam int EXP_FIRST = 0;
    localparam int EXP_DONE  = 7;
`else
    localparam int EXP_FIRST = 1;
    localparam int EXP_DONE  = 8;
`endif

    param_mem_serdes dut (
        .clk               (clk),
        .reset             (reset),
        .mem_start_Xhl     (mem_start_Xhl),
        .mem_rw_Xhl        (mem_rw_Xhl),
        .mem_size_Xhl      (mem_size_Xhl),
        .mem_sext_Xhl      (mem_sext_Xhl),
        .addr_in_Xhl       (addr_in_Xhl),
        .st_nibble_Xhl     (st_nibble_Xhl),
        .st_nibble_val_Xhl (st_nibble_val_Xhl),
        .dmemreq_val       (dmemreq_val),
        .dmemreq_rdy       (dmemreq_rdy),
        .dmemreq_msg_rw    (dmemreq_msg_rw),
        .dmemreq_msg_len   (dmemreq_msg_len),
        .dmemreq_msg_addr  (dmemreq_msg_addr),
        .dmemreq_msg_data  (dmemreq_msg_data),
        .dmemresp_val      (dmemresp_val),
        .dmemresp_msg_data (dmemresp_msg_data),
        .ld_nibble_Xhl     (ld_nibble_Xhl),
        .ld_nibble_val_Xhl (ld_nibble_val_Xhl),
        .busy_Xhl          (busy_Xhl),
        .done_Xhl          (done_Xhl),
        .misalign_Xhl      (misalign_Xhl)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Stimulus helpers (no comparisons): called at posedge+1 with the DUT idle.
    task automatic start_txn(input logic rw, input logic [1:0] size, input logic sext,
                             input logic [31:0] addr);
        mem_rw_Xhl    = rw;
        mem_size_Xhl  = size;
        mem_sext_Xhl  = sext;
        addr_in_Xhl   = addr;
        mem_start_Xhl = 1'b1;
        @(posedge clk); #1;
        mem_start_Xhl = 1'b0;
    endtask

    // Drives the response in offset 0 and records the load stream for 12 cycles.
    task automatic run_stream(input logic [31:0] resp, input int start_at,
                              output logic [31:0] got, output int first_at,
                              output int done_at, output int nval, output int ndone,
                              output logic busy_after, output int nreq);
        got = '0; first_at = -1; done_at = -1; nval = 0; ndone = 0;
        busy_after = 1'b1; nreq = 0;
        for (int c = 0; c < 12; c++) begin
            dmemresp_val      = (c == 0);
            dmemresp_msg_data = resp;
            mem_start_Xhl     = (c == start_at);
            @(negedge clk);
            if (ld_nibble_val_Xhl) begin
                if (first_at < 0) first_at = c;
                if (nval < 8) got[nval*4 +: 4] = ld_nibble_Xhl;
                nval++;
            end
            if (done_Xhl) begin
                if (done_at < 0) done_at = c;
                ndone++;
            end
            if (done_at >= 0 && c == done_at + 1) busy_after = busy_Xhl;
            if (dmemreq_val) nreq++;
            @(posedge clk); #1;
        end
        dmemresp_val  = 1'b0;
        mem_start_Xhl = 1'b0;
    endtask

    task automatic do_load(input logic [1:0] size, input logic sext, input logic [31:0] addr,
                           input logic [31:0] resp, input int start_at,
                           output logic [31:0] got, output int first_at, output int done_at,
                           output int nval, output int ndone, output logic busy_after,
                           output int nreq);
        start_txn(1'b0, size, sext, addr);
        dmemreq_rdy = 1'b1;
        @(posedge clk); #1;
        dmemreq_rdy = 1'b0;
        run_stream(resp, start_at, got, first_at, done_at, nval, ndone, busy_after, nreq);
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_checks++;
        if ({dmemreq_val, ld_nibble_val_Xhl, busy_Xhl, done_Xhl, misalign_Xhl} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b required 00000",
                     {dmemreq_val, ld_nibble_val_Xhl, busy_Xhl, done_Xhl, misalign_Xhl});
        end
        n_checks++;
        if ({dmemreq_msg_addr, dmemreq_msg_data, dmemreq_msg_len, dmemreq_msg_rw, ld_nibble_Xhl} !== 71'd0) begin
            n_fail++;
            $display("FAIL reset_data: addr %h data %h len %0d rw %b nib %h required all 0",
                     dmemreq_msg_addr, dmemreq_msg_data, dmemreq_msg_len, dmemreq_msg_rw, ld_nibble_Xhl);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_load_word;
        logic [31:0] got; int first_at, done_at, nval, ndone, nreq; logic busy_after;
        start_txn(1'b0, 2'd2, 1'b0, 32'h0000_0100);
        dmemreq_rdy = 1'b0;
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            n_checks++;
            if ({dmemreq_val, dmemreq_msg_rw, dmemreq_msg_len, dmemreq_msg_addr} !== {1'b1, 1'b0, 2'd2, 32'h100}) begin
                n_fail++;
                $display("FAIL ldw_req_stall%0d: val %b rw %b len %0d addr %h required 1 0 2 00000100",
                         s, dmemreq_val, dmemreq_msg_rw, dmemreq_msg_len, dmemreq_msg_addr);
            end
            @(posedge clk); #1;
        end
        dmemreq_rdy = 1'b1;
        @(posedge clk); #1;
        dmemreq_rdy = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({dmemreq_val, busy_Xhl, ld_nibble_val_Xhl} !== 3'b010) begin
            n_fail++;
            $display("FAIL ldw_wait: val/busy/ldval %b required 010",
                     {dmemreq_val, busy_Xhl, ld_nibble_val_Xhl});
        end
        @(posedge clk); #1;
        run_stream(32'h89AB_CDEF, -1, got, first_at, done_at, nval, ndone, busy_after, nreq);
        n_checks++;
        if (got !== 32'h89AB_CDEF) begin
            n_fail++; $display("FAIL ldw_data: got %h required 89abcdef", got);
        end
        n_checks++;
        if (first_at !== EXP_FIRST || done_at !== EXP_DONE) begin
            n_fail++; $display("FAIL ldw_timing: first %0d done %0d required %0d %0d",
                               first_at, done_at, EXP_FIRST, EXP_DONE);
        end
        n_checks++;
        if (nval !== 8 || ndone !== 1 || busy_after !== 1'b0) begin
            n_fail++; $display("FAIL ldw_count: nval %0d ndone %0d busy_after %b required 8 1 0",
                               nval, ndone, busy_after);
        end
    endtask

    task automatic test_load_byte;
        logic [31:0] got; int first_at, done_at, nval, ndone, nreq; logic busy_after;
        do_load(2'd0, 1'b1, 32'h0000_0103, 32'h8012_3456, -1, got, first_at, done_at, nval, ndone, busy_after, nreq);
        n_checks++;
        if (got !== 32'hFFFF_FF80 || nval !== 8 || done_at !== EXP_DONE) begin
            n_fail++; $display("FAIL ldb_signed: got %h nval %0d done %0d required ffffff80 8 %0d",
                               got, nval, done_at, EXP_DONE);
        end
        do_load(2'd0, 1'b0, 32'h0000_0103, 32'h8012_3456, -1, got, first_at, done_at, nval, ndone, busy_after, nreq);
        n_checks++;
        if (got !== 32'h0000_0080 || nval !== 8 || done_at !== EXP_DONE) begin
            n_fail++; $display("FAIL ldb_unsigned: got %h nval %0d done %0d required 00000080 8 %0d",
                               got, nval, done_at, EXP_DONE);
        end
        do_load(2'd1, 1'b1, 32'h0000_0102, 32'h9234_0000, -1, got, first_at, done_at, nval, ndone, busy_after, nreq);
        n_checks++;
        if (got !== 32'hFFFF_9234) begin
            n_fail++; $display("FAIL ldh_signed: got %h required ffff9234", got);
        end
    endtask

    task automatic test_store_half;
        logic [3:0] nibs [8] = '{4'h4, 4'h3, 4'h2, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
        int early_req = 0;
        start_txn(1'b1, 2'd1, 1'b0, 32'h0000_0102);
        for (int i = 0; i < 8; i++) begin
            st_nibble_Xhl     = nibs[i];
            st_nibble_val_Xhl = 1'b1;
            @(negedge clk);
            if (dmemreq_val) early_req++;
            @(posedge clk); #1;
            st_nibble_val_Xhl = 1'b0;
            st_nibble_Xhl     = 4'hF;
            if (i < 7 && (i % 2) == 0) begin
                @(negedge clk);
                if (dmemreq_val) early_req++;
                @(posedge clk); #1;
            end
        end
        n_checks++;
        if (early_req !== 0) begin
            n_fail++; $display("FAIL st_early_req: got %0d cycles required 0", early_req);
        end
        dmemresp_val = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({dmemreq_val, dmemreq_msg_rw, dmemreq_msg_len, dmemreq_msg_addr, dmemreq_msg_data}
            !== {1'b1, 1'b1, 2'd1, 32'h102, 32'h1234_0000}) begin
            n_fail++;
            $display("FAIL st_req: val %b rw %b len %0d addr %h data %h required 1 1 1 00000102 12340000",
                     dmemreq_val, dmemreq_msg_rw, dmemreq_msg_len, dmemreq_msg_addr, dmemreq_msg_data);
        end
        n_checks++;
        if (done_Xhl !== 1'b0) begin
            n_fail++; $display("FAIL st_resp_in_req: done %b required 0", done_Xhl);
        end
        @(posedge clk); #1;
        dmemresp_val = 1'b0;
        dmemreq_rdy  = 1'b1;
        @(negedge clk);
        n_checks++;
        if (dmemreq_val !== 1'b1) begin
            n_fail++; $display("FAIL st_req_hold: val %b required 1", dmemreq_val);
        end
        @(posedge clk); #1;
        dmemreq_rdy = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({dmemreq_val, done_Xhl, busy_Xhl} !== 3'b001) begin
            n_fail++; $display("FAIL st_wait: val/done/busy %b required 001", {dmemreq_val, done_Xhl, busy_Xhl});
        end
        @(posedge clk); #1;
        dmemresp_val = 1'b1;
        @(negedge clk);
        n_checks++;
        if (done_Xhl !== 1'b1) begin
            n_fail++; $display("FAIL st_ack_done: done %b required 1", done_Xhl);
        end
        @(posedge clk); #1;
        dmemresp_val = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy_Xhl, done_Xhl} !== 2'b00) begin
            n_fail++; $display("FAIL st_after: busy/done %b required 00", {busy_Xhl, done_Xhl});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_misalign;
        int req_seen = 0;
        start_txn(1'b0, 2'd2, 1'b0, 32'h0000_0101);
        @(negedge clk);
        n_checks++;
        if ({misalign_Xhl, done_Xhl, busy_Xhl, dmemreq_val} !== 4'b1110) begin
            n_fail++; $display("FAIL mis_cycle1: mis/done/busy/val %b required 1110",
                               {misalign_Xhl, done_Xhl, busy_Xhl, dmemreq_val});
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if ({misalign_Xhl, done_Xhl, busy_Xhl} !== 3'b100) begin
            n_fail++; $display("FAIL mis_cycle2: mis/done/busy %b required 100",
                               {misalign_Xhl, done_Xhl, busy_Xhl});
        end
        for (int c = 0; c < 3; c++) begin
            if (dmemreq_val) req_seen++;
            @(posedge clk); #1;
            @(negedge clk);
        end
        n_checks++;
        if (req_seen !== 0) begin
            n_fail++; $display("FAIL mis_no_req: got %0d request cycles required 0", req_seen);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        logic [31:0] got; int first_at, done_at, nval, ndone, nreq; logic busy_after;
        int late_val = 0, late_done = 0;
        start_txn(1'b0, 2'd2, 1'b0, 32'h0000_0040);
        @(negedge clk);
        n_checks++;
        if ({dmemreq_val, misalign_Xhl} !== 2'b10) begin
            n_fail++; $display("FAIL rst_pre: val/mis %b required 10", {dmemreq_val, misalign_Xhl});
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if ({dmemreq_val, busy_Xhl} !== 2'b00) begin
            n_fail++; $display("FAIL rst_async_req: val/busy %b required 00", {dmemreq_val, busy_Xhl});
        end
        @(posedge clk); #1;
        reset = 1'b0;
        start_txn(1'b0, 2'd2, 1'b0, 32'h0000_0040);
        dmemreq_rdy = 1'b1;
        @(posedge clk); #1;
        dmemreq_rdy = 1'b0;
        reset = 1'b1;
        #1;
        n_checks++;
        if (busy_Xhl !== 1'b0) begin
            n_fail++; $display("FAIL rst_wait_busy: busy %b required 0", busy_Xhl);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            dmemresp_val      = (c == 0);
            dmemresp_msg_data = 32'hFFFF_FFFF;
            @(negedge clk);
            if (ld_nibble_val_Xhl) late_val++;
            if (done_Xhl) late_done++;
            @(posedge clk); #1;
        end
        dmemresp_val = 1'b0;
        n_checks++;
        if (late_val !== 0 || late_done !== 0) begin
            n_fail++; $display("FAIL rst_late_resp: nval %0d ndone %0d required 0 0", late_val, late_done);
        end
        do_load(2'd2, 1'b0, 32'h0000_0200, 32'h1357_2468, -1, got, first_at, done_at, nval, ndone, busy_after, nreq);
        n_checks++;
        if (got !== 32'h1357_2468 || done_at !== EXP_DONE || nval !== 8) begin
            n_fail++; $display("FAIL rst_next_load: got %h done %0d nval %0d required 13572468 %0d 8",
                               got, done_at, nval, EXP_DONE);
        end
    endtask

    task automatic test_start_in_stream;
        logic [31:0] got; int first_at, done_at, nval, ndone, nreq; logic busy_after;
        do_load(2'd2, 1'b0, 32'h0000_0080, 32'hDEAD_BEEF, 3, got, first_at, done_at, nval, ndone, busy_after, nreq);
        n_checks++;
        if (got !== 32'hDEAD_BEEF || first_at !== EXP_FIRST || done_at !== EXP_DONE) begin
            n_fail++; $display("FAIL stream_start_data: got %h first %0d done %0d required deadbeef %0d %0d",
                               got, first_at, done_at, EXP_FIRST, EXP_DONE);
        end
        n_checks++;
        if (nreq !== 0 || ndone !== 1 || busy_after !== 1'b0) begin
            n_fail++; $display("FAIL stream_start_ignored: nreq %0d ndone %0d busy_after %b required 0 1 0",
                               nreq, ndone, busy_after);
        end
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_load_byte();
        test_store_half();
        test_misalign();
        test_reset_mid();
        test_start_in_stream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
